// File: rtl/led_show_sched.sv
// =============================================================================
//  Module      : led_show_sched
//  Description : Round-robin scheduler granting one requester at a time access
//                to the LED pattern generator for a programmable dwell time.
//                Optional macro LED_SCHED_STATS_EN adds a saturating grant_count.
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module led_show_sched #(
    parameter int NUM_REQ = 4,
    parameter int DWELL_W = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   gen_enable,
    output logic [1:0]             gen_mode,
    output logic                   busy,
    output logic                   expired
`ifdef LED_SCHED_STATS_EN
    ,
    output logic [15:0]            grant_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_COOL  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [IDX_W-1:0]   r_winner;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_winner;
    logic [IDX_W-1:0]   w_cur_winner;
    logic               w_found;
    int                 w_idx;
    logic [DWELL_W-1:0] r_cnt;
    logic               w_timeout;
    logic               w_drop;
    logic [NUM_REQ-1:0] w_grant_nxt;
    logic [1:0]         w_mode_nxt;
    logic               w_en_nxt;
    logic               w_busy_nxt;
    logic               w_exp_nxt;

    // Round-robin search starting one past the previous winner, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_last;
        w_idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last) + k) % NUM_REQ;
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx[IDX_W-1:0];
            end
        end
    end

    // A zero count means unlimited dwell, so only a count of 1 can time out.
    assign w_timeout = (r_cnt == DWELL_W'(1));
    assign w_drop    = !req[r_winner];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
            S_GRANT: w_state_nxt = S_HOLD;
            S_HOLD:  if (w_timeout || w_drop) w_state_nxt = S_COOL;
            S_COOL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming state; registered below.
    always_comb begin
        w_cur_winner = (r_state == S_IDLE) ? w_winner : r_winner;
        w_grant_nxt  = '0;
        if ((w_state_nxt == S_GRANT) || (w_state_nxt == S_HOLD)) begin
            w_grant_nxt = NUM_REQ'(1) << w_cur_winner;
        end
        w_mode_nxt = gen_mode;
        if ((r_state == S_IDLE) && w_found) begin
            w_mode_nxt = req_mode[2*w_winner +: 2];
        end
        w_en_nxt   = (w_state_nxt == S_HOLD);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_exp_nxt  = (r_state == S_HOLD) && w_timeout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant      <= '0;
            gen_enable <= 1'b0;
            gen_mode   <= 2'b00;
            busy       <= 1'b0;
            expired    <= 1'b0;
        end else begin
            grant      <= w_grant_nxt;
            gen_enable <= w_en_nxt;
            gen_mode   <= w_mode_nxt;
            busy       <= w_busy_nxt;
            expired    <= w_exp_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_winner <= '0;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_cnt    <= '0;
        end else begin
            if ((r_state == S_IDLE) && w_found) begin
                r_winner <= w_winner;
            end
            if (r_state == S_COOL) begin
                r_last <= r_winner;
            end
            if (r_state == S_GRANT) begin
                r_cnt <= dwell;
            end else if ((r_state == S_HOLD) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - DWELL_W'(1);
            end
        end
    end

`ifdef LED_SCHED_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_count <= 16'h0000;
        end else if ((r_state == S_IDLE) && w_found && (grant_count != 16'hFFFF)) begin
            grant_count <= grant_count + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_led_show_sched.sv
// =============================================================================
//  Module      : tb_led_show_sched
//  Description : Scoreboard bench for led_show_sched; each grant is checked as
//                one transaction (owner, mode, enable cycles, expired pulse).
//  Revision    : 1.0  initial release
// =============================================================================
`default_nettype none

module tb_led_show_sched;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [7:0]  req_mode;
    logic [23:0] dwell;
    logic [3:0]  grant;
    logic        gen_enable;
    logic [1:0]  gen_mode;
    logic        busy;
    logic        expired;
`ifdef LED_SCHED_STATS_EN
    logic [15:0] grant_count;
`endif

    led_show_sched #(.NUM_REQ(4), .DWELL_W(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_mode   (req_mode),
        .dwell      (dwell),
        .grant      (grant),
        .gen_enable (gen_enable),
        .gen_mode   (gen_mode),
        .busy       (busy),
        .expired    (expired)
`ifdef LED_SCHED_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  g;
        logic [1:0]  m;
        logic [15:0] en;
        logic        ex;
    } txn_t;

    txn_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic txn_t mk(input logic [3:0] g, input logic [1:0] m,
                                input int en, input logic ex);
        txn_t t;
        t.g  = g;
        t.m  = m;
        t.en = en[15:0];
        t.ex = ex;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
        end
    endtask

    // Monitor: one transaction per grant, closed when grant falls into COOL.
    logic [3:0]  mon_prev = '0;
    logic [15:0] mon_en   = '0;
    logic [1:0]  mon_mode = '0;
    always @(negedge clk) begin
        if (reset) begin
            mon_prev = '0;
            mon_en   = '0;
        end else begin
            if (gen_enable) begin
                if (mon_en != 0 && gen_mode != mon_mode) begin
                    errors++;
                    $display("FAIL mode_stable: got %0d expected %0d", gen_mode, mon_mode);
                end
                mon_mode = gen_mode;
                mon_en   = mon_en + 16'd1;
            end
            if (mon_prev != 0 && grant == 0) begin
                txn_t act;
                txn_t want;
                act.g  = mon_prev;
                act.m  = mon_mode;
                act.en = mon_en;
                act.ex = expired;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL txn_unexpected: got g=%b m=%0d en=%0d ex=%b expected none",
                             act.g, act.m, act.en, act.ex);
                end else begin
                    want = exp_q.pop_front();
                    if (act !== want) begin
                        errors++;
                        $display("FAIL txn: got g=%b m=%0d en=%0d ex=%b expected g=%b m=%0d en=%0d ex=%b",
                                 act.g, act.m, act.en, act.ex, want.g, want.m, want.en, want.ex);
                    end
                end
                if (!busy) begin
                    errors++;
                    $display("FAIL cool_busy: got 0 expected 1");
                end
                mon_en = '0;
            end else if (expired) begin
                errors++;
                $display("FAIL spurious_expired: got 1 expected 0 at %0t", $time);
            end
            mon_prev = grant;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant_end(input int maxc);
        logic [3:0] p;
        bit done;
        p    = grant;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            tick();
            if (p != 0 && grant == 0) done = 1'b1;
            p = grant;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_grant_end: got timeout expected grant release");
        end
    endtask

    task automatic wait_enable(input int maxc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < maxc && !done; i++) begin
            tick();
            if (gen_enable) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_enable: got timeout expected gen_enable");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_mode = '0;
        dwell    = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_en", {31'd0, gen_enable}, 32'd0);
        chk("rst_mode", {30'd0, gen_mode}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_expired", {31'd0, expired}, 32'd0);

        // Single request with timeout
        exp_q.push_back(mk(4'b0100, 2'd3, 5, 1'b1));
        req = 4'b0100; req_mode = 8'b0011_0000; dwell = 24'd5;
        tick();
        chk("s1_grant", {28'd0, grant}, 32'h4);
        chk("s1_en_in_grant", {31'd0, gen_enable}, 32'd0);
        chk("s1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("s1_en", {31'd0, gen_enable}, 32'd1);
        chk("s1_mode", {30'd0, gen_mode}, 32'd3);
        wait_grant_end(20);
        req = '0;
        tick();
        chk("s1_busy_idle", {31'd0, busy}, 32'd0);
        chk("s1_expired_once", {31'd0, expired}, 32'd0);

        // Round-robin order from reset
        pulse_reset();
        exp_q.push_back(mk(4'b0001, 2'd0, 3, 1'b1));
        exp_q.push_back(mk(4'b0010, 2'd1, 3, 1'b1));
        exp_q.push_back(mk(4'b0100, 2'd2, 3, 1'b1));
        exp_q.push_back(mk(4'b1000, 2'd3, 3, 1'b1));
        exp_q.push_back(mk(4'b0001, 2'd0, 3, 1'b1));
        req = 4'b1111; req_mode = 8'b11_10_01_00; dwell = 24'd3;
        for (int i = 0; i < 5; i++) wait_grant_end(20);
        req = '0;
        tick();

        // Early release after 10 enable cycles
        exp_q.push_back(mk(4'b0001, 2'd2, 10, 1'b0));
        req = 4'b0001; req_mode = 8'h02; dwell = 24'd100;
        wait_enable(10);
        repeat (9) tick();
        req = '0;
        wait_grant_end(5);
        tick();

        // Unlimited dwell
        exp_q.push_back(mk(4'b0010, 2'd1, 1000, 1'b0));
        req = 4'b0010; req_mode = 8'h04; dwell = 24'd0;
        wait_enable(10);
        repeat (999) tick();
        chk("s4_en_held", {31'd0, gen_enable}, 32'd1);
        req = '0;
        wait_grant_end(5);
        tick();

        // Asynchronous reset in HOLD
        req = 4'b0100; req_mode = 8'h30; dwell = 24'd20;
        wait_enable(10);
        repeat (3) tick();
        reset = 1'b1;
        req   = '0;
        #1;
        chk("s5_en_async", {31'd0, gen_enable}, 32'd0);
        chk("s5_grant_async", {28'd0, grant}, 32'd0);
        chk("s5_busy_async", {31'd0, busy}, 32'd0);
        chk("s5_expired_async", {31'd0, expired}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        exp_q.push_back(mk(4'b0001, 2'd0, 2, 1'b1));
        req = 4'b1111; req_mode = 8'b11_10_01_00; dwell = 24'd2;
        tick();
        chk("s5_first_winner", {28'd0, grant}, 32'h1);
        wait_grant_end(20);
        req = '0;
        tick();

        // Minimum dwell, three grants after reset
        pulse_reset();
        exp_q.push_back(mk(4'b0001, 2'd0, 1, 1'b1));
        exp_q.push_back(mk(4'b0010, 2'd1, 1, 1'b1));
        exp_q.push_back(mk(4'b0100, 2'd2, 1, 1'b1));
        req = 4'b0111; dwell = 24'd1;
        for (int i = 0; i < 3; i++) wait_grant_end(20);
        req = '0;
        tick();
`ifdef LED_SCHED_STATS_EN
        chk("stats_count3", {16'd0, grant_count}, 32'd3);
`endif

        // Request dropped during GRANT still gets one HOLD cycle
        exp_q.push_back(mk(4'b1000, 2'd3, 1, 1'b0));
        req = 4'b1000; dwell = 24'd50;
        tick();
        chk("s7_grant", {28'd0, grant}, 32'h8);
        req = '0;
        wait_grant_end(10);
        tick();
        tick();

        pulse_reset();
`ifdef LED_SCHED_STATS_EN
        chk("stats_after_reset", {16'd0, grant_count}, 32'd0);
`endif
        tick();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
